// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard sequencer: FSM state codes and
// stall/flush bit positions used by hazard_ctrl and its helpers.
package hazard_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_MDU_BUSY = 2'd2;

    localparam int STL_IFID  = 0;
    localparam int STL_IDEX  = 1;
    localparam int STL_PC    = 2;
    localparam int STL_EXMEM = 3;
    localparam int STL_MEMWB = 4;

    localparam logic [4:0] STL_ALL_HOLD = 5'b11111;
    localparam logic [4:0] STL_MEM_HOLD = 5'b01111;
    localparam logic [4:0] STL_MDU_HOLD = 5'b00111;

endpackage

// File: rtl/hazard_ldu_detect.sv
// Load-use compare: flags an ID-stage instruction that reads the destination
// of a load currently sitting in EX (x0 never creates a dependency).
module hazard_ldu_detect
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              hazard
);

    assign hazard = ex_is_load && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: stall/flush vectors, PC redirect and memory-wait timeout.
// Optional HAZARD_PERF_EN adds saturating stall-cycle and flush counters.
//
// state       | meaning
// RUN         | normal flow; load-use and redirects handled here
// MEM_WAIT    | data memory not ready; front four stages held, WB drains
// MDU_BUSY    | multi-cycle MDU op occupies EX; IF/ID, ID/EX and PC held
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int REG_AW      = 5,
    parameter int MDU_LAT     = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mdu_start,
    input  logic              ex_br_taken,
    input  logic [XLEN-1:0]   ex_br_target,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic [4:0]        do_stall,
    output logic [4:0]        flush,
    output logic              branch,
    output logic [XLEN-1:0]   branch_addr,
    output logic              mem_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       perf_stall_cyc,
    output logic [31:0]       perf_flush_cnt
`endif
);

    localparam logic [9:0] TIMEOUT  = 10'(MEM_TIMEOUT);
    localparam logic [7:0] MDU_LOAD = 8'(MDU_LAT - 1);

    logic [1:0]      state;
    logic [7:0]      mdu_cnt;
    logic [7:0]      mdu_cnt_nxt;
    logic [9:0]      wait_cnt;
    logic            pend;
    logic [XLEN-1:0] pend_addr;

    logic run_like, mdu_active, timeout_hit, mem_hold, ldu_hit, latch_br, issue_pend;

    hazard_ldu_detect #(.REG_AW(REG_AW)) u_ldu (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .hazard     (ldu_hit)
    );

    always_comb begin
        run_like    = (state == ST_RUN) || ((state == ST_MDU_BUSY) && (mdu_cnt == 8'd0));
        mdu_active  = (state == ST_MDU_BUSY) && (mdu_cnt != 8'd0);
        timeout_hit = (state == ST_MEM_WAIT) && !mem_ready && (wait_cnt >= TIMEOUT);
        if (state == ST_MEM_WAIT) mem_hold = !mem_ready && !timeout_hit;
        else                      mem_hold = mem_req && !mem_ready;

        if (run_like && ex_mdu_start) mdu_cnt_nxt = MDU_LOAD;
        else if (mdu_cnt != 8'd0)     mdu_cnt_nxt = mdu_cnt - 8'd1;
        else                          mdu_cnt_nxt = mdu_cnt;

        do_stall    = '0;
        flush       = '0;
        branch      = 1'b0;
        branch_addr = '0;
        mem_err     = 1'b0;
        latch_br    = 1'b0;
        issue_pend  = 1'b0;
        if (reset) begin
            do_stall = '0;
        end else if (!go) begin
            do_stall = STL_ALL_HOLD;
        end else begin
            // A taken branch that cannot redirect now is parked until the pipe is free.
            latch_br = ex_br_taken && !pend && (mem_hold || (state == ST_MEM_WAIT) || mdu_active);
            if (mem_hold) begin
                do_stall         = STL_MEM_HOLD;
                flush[STL_MEMWB] = 1'b1;
            end else if (state == ST_MEM_WAIT) begin
                mem_err = timeout_hit;
            end else if (mdu_active) begin
                do_stall         = STL_MDU_HOLD;
                flush[STL_EXMEM] = 1'b1;
            end else if (pend) begin
                branch          = 1'b1;
                branch_addr     = pend_addr;
                flush[STL_IFID] = 1'b1;
                flush[STL_IDEX] = 1'b1;
                issue_pend      = 1'b1;
            end else if (ex_br_taken) begin
                branch          = 1'b1;
                branch_addr     = ex_br_target;
                flush[STL_IFID] = 1'b1;
                flush[STL_IDEX] = 1'b1;
            end else if (ldu_hit) begin
                do_stall[STL_PC]   = 1'b1;
                do_stall[STL_IFID] = 1'b1;
                flush[STL_IDEX]    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            mdu_cnt   <= '0;
            wait_cnt  <= '0;
            pend      <= 1'b0;
            pend_addr <= '0;
        end else if (go) begin
            mdu_cnt <= mdu_cnt_nxt;
            if (issue_pend) begin
                pend <= 1'b0;
            end else if (latch_br) begin
                pend      <= 1'b1;
                pend_addr <= ex_br_target;
            end
            // MDU keeps counting under a memory wait; resume busy only if it has time left.
            if (state == ST_MEM_WAIT) begin
                if (mem_hold) wait_cnt <= wait_cnt + 10'd1;
                else          state    <= (mdu_cnt_nxt != 8'd0) ? ST_MDU_BUSY : ST_RUN;
            end else if (mem_hold) begin
                state    <= ST_MEM_WAIT;
                wait_cnt <= 10'd1;
            end else if (mdu_cnt_nxt != 8'd0) begin
                state <= ST_MDU_BUSY;
            end else begin
                state <= ST_RUN;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cyc <= '0;
            perf_flush_cnt <= '0;
        end else if (go) begin
            if (do_stall[STL_PC] && (perf_stall_cyc != 32'hFFFF_FFFF))
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            if (branch && (perf_flush_cnt != 32'hFFFF_FFFF))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios followed by random traffic, all
// checked against a cycle-level reference model of the sequencing rules.
module tb_hazard_ctrl;

    localparam int XLEN        = 32;
    localparam int REG_AW      = 5;
    localparam int MDU_LAT     = 4;
    localparam int MEM_TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              reset, go;
    logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
    logic              id_use_rs1, id_use_rs2, ex_is_load, ex_mdu_start, ex_br_taken;
    logic [XLEN-1:0]   ex_br_target;
    logic              mem_req, mem_ready;
    logic [4:0]        do_stall, flush;
    logic              branch, mem_err;
    logic [XLEN-1:0]   branch_addr;
`ifdef HAZARD_PERF_EN
    logic [31:0]       perf_stall_cyc, perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(
        .XLEN(XLEN), .REG_AW(REG_AW), .MDU_LAT(MDU_LAT), .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .go(go),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_mdu_start(ex_mdu_start),
        .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .do_stall(do_stall), .flush(flush), .branch(branch), .branch_addr(branch_addr),
        .mem_err(mem_err)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: memory wait flag and cycles waited, MDU cycles left, parked redirect.
    bit          m_in_wait  = 1'b0;
    int          m_wait_n   = 0;
    int          m_mdu_left = 0;
    bit          m_pend     = 1'b0;
    logic [31:0] m_pend_addr = '0;
    logic [4:0]  e_stall, e_flush;
    logic        e_br, e_err;
    logic [31:0] e_addr;
    bit          e_mem_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit load_use();
        return ex_is_load && ex_rd != 0 &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    endfunction

    task automatic model_expect();
        e_stall = '0; e_flush = '0; e_br = 1'b0; e_addr = '0; e_err = 1'b0;
        e_mem_busy = m_in_wait ? (!mem_ready && m_wait_n < MEM_TIMEOUT) : (mem_req && !mem_ready);
        if (reset) begin
            e_stall = '0;
        end else if (!go) begin
            e_stall = 5'b11111;
        end else if (e_mem_busy) begin
            e_stall = 5'b01111; e_flush = 5'b10000;
        end else if (m_in_wait) begin
            e_err = !mem_ready;
        end else if (m_mdu_left > 0) begin
            e_stall = 5'b00111; e_flush = 5'b01000;
        end else if (m_pend) begin
            e_br = 1'b1; e_addr = m_pend_addr; e_flush = 5'b00011;
        end else if (ex_br_taken) begin
            e_br = 1'b1; e_addr = ex_br_target; e_flush = 5'b00011;
        end else if (load_use()) begin
            e_stall = 5'b00101; e_flush = 5'b00010;
        end
    endtask

    task automatic model_commit();
        int left_next;
        if (reset) begin
            m_in_wait = 1'b0; m_wait_n = 0; m_mdu_left = 0; m_pend = 1'b0; m_pend_addr = '0;
        end else if (go) begin
            left_next = m_mdu_left;
            if (!m_in_wait && m_mdu_left == 0 && ex_mdu_start) left_next = MDU_LAT - 1;
            else if (m_mdu_left > 0) left_next = m_mdu_left - 1;
            if (!m_in_wait && m_mdu_left == 0 && m_pend && !e_mem_busy) begin
                m_pend = 1'b0;
            end else if (ex_br_taken && !m_pend && (e_mem_busy || m_in_wait || m_mdu_left > 0)) begin
                m_pend = 1'b1; m_pend_addr = ex_br_target;
            end
            if (m_in_wait) begin
                if (e_mem_busy) m_wait_n++;
                m_in_wait = e_mem_busy;
            end else if (e_mem_busy) begin
                m_in_wait = 1'b1; m_wait_n = 1;
            end
            m_mdu_left = left_next;
        end
    endtask

    task automatic settle_check();
        @(negedge clk);
        model_expect();
        chk("m_stall", 32'(do_stall), 32'(e_stall));
        chk("m_flush", 32'(flush), 32'(e_flush));
        chk("m_branch", 32'(branch), 32'(e_br));
        chk("m_addr", branch_addr, e_addr);
        chk("m_err", 32'(mem_err), 32'(e_err));
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic set_idle();
        go = 1'b1; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_is_load = 1'b0; ex_rd = '0; ex_mdu_start = 1'b0; ex_br_taken = 1'b0;
        ex_br_target = '0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        int rdy_pct;
        set_idle();
        reset = 1'b1;
        repeat (2) begin
            settle_check(); chk("rst_stall", 32'(do_stall), 0); chk("rst_branch", 32'(branch), 0); tick();
        end
        reset = 1'b0;

        // load-use hit, then rd = x0 gives no hazard
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        settle_check(); chk("ldu_stall", 32'(do_stall), 5'b00101); chk("ldu_flush", 32'(flush), 5'b00010); tick();
        ex_rd = 5'd0; id_rs1 = 5'd0;
        settle_check(); chk("ldu_rd0", 32'(do_stall), 0); tick();

        // taken branch, alone and overriding a load-use hit
        set_idle(); ex_br_taken = 1'b1; ex_br_target = 32'h100;
        settle_check(); chk("br_b", 32'(branch), 1); chk("br_addr", branch_addr, 32'h100);
        chk("br_flush", 32'(flush), 5'b00011); tick();
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        settle_check(); chk("br_ldu_stall", 32'(do_stall), 0); chk("br_ldu_b", 32'(branch), 1); tick();
        set_idle();
        settle_check(); chk("br_off", 32'(branch), 0); tick();

        // memory wait with a branch arriving mid-wait
        mem_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            ex_br_taken  = (c == 2);
            ex_br_target = (c == 2) ? 32'h40 : 32'h0;
            settle_check(); chk("mw_stall", 32'(do_stall), 5'b01111); chk("mw_nobr", 32'(branch), 0); tick();
        end
        ex_br_taken = 1'b0; ex_br_target = '0; mem_ready = 1'b1;
        settle_check(); chk("mw_exit_stall", 32'(do_stall), 0); chk("mw_exit_br", 32'(branch), 0); tick();
        mem_req = 1'b0; mem_ready = 1'b0;
        settle_check(); chk("mw_redir", 32'(branch), 1); chk("mw_addr", branch_addr, 32'h40); tick();
        settle_check(); chk("mw_once", 32'(branch), 0); tick();

        // timeout: memory never answers
        mem_req = 1'b1;
        for (int c = 1; c <= MEM_TIMEOUT; c++) begin
            settle_check(); chk("to_stall", 32'(do_stall), 5'b01111); chk("to_noerr", 32'(mem_err), 0); tick();
        end
        settle_check(); chk("to_err", 32'(mem_err), 1); chk("to_release", 32'(do_stall), 0); tick();
        mem_req = 1'b0;
        settle_check(); chk("to_pulse", 32'(mem_err), 0); tick();

        // MDU op: start cycle, MDU_LAT-1 held cycles, then free
        ex_mdu_start = 1'b1;
        settle_check(); chk("mdu_start", 32'(do_stall), 0); tick();
        ex_mdu_start = 1'b0;
        for (int c = 1; c < MDU_LAT; c++) begin
            settle_check(); chk("mdu_stall", 32'(do_stall), 5'b00111); chk("mdu_flush", 32'(flush), 5'b01000); tick();
        end
        settle_check(); chk("mdu_done", 32'(do_stall), 0); tick();

        // MDU op frozen by go=0 keeps its remaining count
        ex_mdu_start = 1'b1; settle_check(); tick(); ex_mdu_start = 1'b0;
        settle_check(); chk("mdug_stall1", 32'(do_stall), 5'b00111); tick();
        go = 1'b0;
        repeat (3) begin
            settle_check(); chk("go0_stall", 32'(do_stall), 5'b11111); chk("go0_flush", 32'(flush), 0); tick();
        end
        go = 1'b1;
        repeat (MDU_LAT - 2) begin
            settle_check(); chk("mdug_stall2", 32'(do_stall), 5'b00111); tick();
        end
        settle_check(); chk("mdug_done", 32'(do_stall), 0); tick();

        // reset in the middle of a wait drops the parked redirect
        mem_req = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            ex_br_taken = (c == 2); ex_br_target = 32'h80;
            settle_check(); tick();
        end
        ex_br_taken = 1'b0; reset = 1'b1;
        repeat (3) begin
            settle_check(); chk("rmw_stall", 32'(do_stall), 0); chk("rmw_flush", 32'(flush), 0);
            chk("rmw_err", 32'(mem_err), 0); tick();
        end
        reset = 1'b0; mem_req = 1'b0;
        settle_check(); chk("rmw_run", 32'(do_stall), 0); chk("rmw_nobr", 32'(branch), 0); tick();

        // random traffic, alternating slow and fast memory phases
        for (int i = 0; i < 800; i++) begin
            rdy_pct      = ((i / 100) % 2 == 1) ? 1 : 6;
            reset        = ($urandom_range(0, 99) == 0);
            go           = ($urandom_range(0, 9) != 0);
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            id_use_rs1   = 1'($urandom);
            id_use_rs2   = 1'($urandom);
            ex_is_load   = 1'($urandom);
            ex_rd        = 5'($urandom_range(0, 3));
            ex_mdu_start = ($urandom_range(0, 11) == 0);
            ex_br_taken  = ($urandom_range(0, 6) == 0);
            ex_br_target = $urandom;
            mem_req      = ($urandom_range(0, 4) == 0);
            mem_ready    = ($urandom_range(0, 9) < rdy_pct);
            settle_check();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
